// File: rtl/wb_port_arb.sv
// Write-port arbiter for the register file: the MEM/WB pipeline write always wins,
// and long-latency results wait in a small in-order queue until a slot is free.
module wb_port_arb #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipe_we_i,
    input  logic [ADDR_W-1:0]            pipe_waddr_i,
    input  logic [DATA_W-1:0]            pipe_wdata_i,
    input  logic                         lu_valid_i,
    output logic                         lu_ready_o,
    input  logic [ADDR_W-1:0]            lu_waddr_i,
    input  logic [DATA_W-1:0]            lu_wdata_i,
    output logic                         rf_we_o,
    output logic [ADDR_W-1:0]            rf_waddr_o,
    output logic [DATA_W-1:0]            rf_wdata_o,
    output logic                         stall_o,
    output logic [$clog2(DEPTH+0):0]     pending_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic pipe_busy, head_valid, head_dead, head_hit;
    logic push, pop, drain, waiting;

    assign pipe_busy  = pipe_we_i && (pipe_waddr_i != '0);
    assign lu_ready_o = (count_q < CNT_W'(DEPTH));
    assign push       = lu_valid_i && lu_ready_o && (lu_waddr_i != '0);
    assign head_valid = (count_q != '0);
    assign head_dead  = head_valid && kill_q[head_q];
    // A busy pipe write to the head's register kills it now; it must not count as starving.
    assign head_hit   = pipe_busy && (addr_q[head_q] == pipe_waddr_i);
    assign drain      = head_valid && !head_dead && !pipe_busy;
    assign pop        = drain || head_dead;
    assign waiting    = head_valid && !head_dead && !drain && !head_hit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        kill_d     = kill_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        starve_d   = '0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (pipe_busy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == pipe_waddr_i) kill_d[i] = 1'b1;
            end
        end
        if (push) begin
            kill_d[tail_q] = pipe_busy && (lu_waddr_i == pipe_waddr_i);
            tail_d         = tail_q + PTR_W'(1);
        end
        if (pop) head_d = head_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pipe_busy) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_waddr_i;
            rf_wdata_d = pipe_wdata_i;
        end else if (drain) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_q[head_q];
            rf_wdata_d = data_q[head_q];
        end

        if (waiting) begin
            starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
        end
        stall_d = (starve_d == STV_W'(STARVE_LIMIT));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            kill_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            kill_q     <= kill_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // NOTE: queue payload is not reset; occupancy and kill bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= lu_waddr_i;
            data_q[tail_q] <= lu_wdata_i;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign stall_o    = stall_q;
    assign pending_o  = count_q;

endmodule
